// File: rtl/dmem_pkg.sv
// Shared types, sizing defaults, preload image and address decode for the data RAM.
// The preload image is applied only when the DMEM_PRELOAD_EN macro is defined.
package dmem_pkg;

  localparam int unsigned DMEM_WORD_W       = 32;
  localparam int unsigned DMEM_RAM_SIZE     = 256;
  localparam int unsigned DMEM_RAM_SIZE_BIT = 8;
  localparam int unsigned DMEM_PRELOAD_LEN  = 9;

  typedef logic [DMEM_WORD_W-1:0] dmem_word_t;

  // Word 0 holds the element count; words 1..8 are the display data set.
  localparam dmem_word_t DMEM_PRELOAD_IMG [DMEM_PRELOAD_LEN] = '{
    32'd8,
    32'h0000_1234, 32'h0000_0042, 32'h0000_ABCD, 32'h0000_0007,
    32'h0000_9000, 32'h0000_0311, 32'h0000_FFFF, 32'h0000_0001
  };

  // In range only when every bit above the word index is clear, so no wrap-around.
  function automatic logic dmem_in_range(input logic [31:0] addr,
                                         input int unsigned size_bit);
    return (addr >> (size_bit + 2)) == 32'd0;
  endfunction

  // Byte address to word index; the two byte-select bits are dropped.
  function automatic logic [31:0] dmem_word_index(input logic [31:0] addr,
                                                  input int unsigned size_bit);
    logic [31:0] mask;
    mask = (32'd1 << size_bit) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/data_mem_unit.sv
// Word-organised data RAM: combinational read, rising-edge write, asynchronous clear.
// Define DMEM_PRELOAD_EN to have reset load the fixed display image instead of zeros.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_SIZE     = DMEM_RAM_SIZE,
  parameter int unsigned RAM_SIZE_BIT = DMEM_RAM_SIZE_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data
);

  dmem_word_t              mem [RAM_SIZE];
  logic [RAM_SIZE_BIT-1:0] idx;
  logic                    in_range;
  logic                    wr_en;

  assign idx      = RAM_SIZE_BIT'(dmem_word_index(Address, RAM_SIZE_BIT));
  assign in_range = dmem_in_range(Address, RAM_SIZE_BIT);
  assign wr_en    = MemWrite && in_range;

  // Reset value of each word, selected at build time.
  function automatic dmem_word_t reset_word(input int unsigned i);
`ifdef DMEM_PRELOAD_EN
    if (i < DMEM_PRELOAD_LEN)
      return DMEM_PRELOAD_IMG[i];
    else
      return '0;
`else
    return (i < RAM_SIZE) ? dmem_word_t'(0) : dmem_word_t'(0);
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RAM_SIZE; i++)
        mem[i] <= reset_word(i);
    end else if (wr_en) begin
      mem[idx] <= Write_data;
    end
  end

  // No write-through: a same-cycle write becomes visible only after the edge.
  assign Read_data = (MemRead && in_range) ? mem[idx] : '0;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed plus randomized bench for data_mem_unit against an array reference model.
// Compile with DMEM_PRELOAD_EN to exercise the preloaded reset image.
module tb_data_mem_unit;

  localparam int unsigned RAM_SIZE     = 256;
  localparam int unsigned RAM_SIZE_BIT = 8;
  localparam logic [31:0] TOP_BYTE     = RAM_SIZE * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  int ncmp = 0;
  int nfail = 0;

  logic [31:0] model [RAM_SIZE];

  data_mem_unit #(.RAM_SIZE(RAM_SIZE), .RAM_SIZE_BIT(RAM_SIZE_BIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < RAM_SIZE; i++) model[i] = 32'h0;
`ifdef DMEM_PRELOAD_EN
    model[0] = 32'd8;
    model[1] = 32'h0000_1234; model[2] = 32'h0000_0042;
    model[3] = 32'h0000_ABCD; model[4] = 32'h0000_0007;
    model[5] = 32'h0000_9000; model[6] = 32'h0000_0311;
    model[7] = 32'h0000_FFFF; model[8] = 32'h0000_0001;
`endif
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic rd);
    if (!rd || addr >= TOP_BYTE) return 32'h0;
    return model[addr / 4];
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    ncmp++;
    assert (Read_data === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, Read_data, exp);
    end
  endtask

  task automatic probe(input string tag, input logic [31:0] addr, input logic rd);
    Address = addr;
    MemRead = rd;
    #1;
    check(tag, model_read(addr, rd));
  endtask

  // One bus cycle driven from the falling edge; checks read before and after the rising edge.
  task automatic bus_op(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic rd, input logic wr);
    @(negedge clk);
    Address = addr; Write_data = wd; MemRead = rd; MemWrite = wr;
    #1;
    check({tag, "_pre"}, model_read(addr, rd));
    @(posedge clk);
    if (wr && addr < TOP_BYTE) model[addr / 4] = wd;
    #1;
    check({tag, "_post"}, model_read(addr, rd));
    MemWrite = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    Address = 32'h0; Write_data = 32'h0;
    #2;
    reset = 1'b0;
    model_reset();
    probe("reset_rd_0x4", 32'h4, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < RAM_SIZE; i++) probe("post_reset_sweep", i * 4, 1'b1);

`ifdef DMEM_PRELOAD_EN
    Address = 32'h0;  MemRead = 1'b1; #1; check("preload_0x0", 32'd8);
    Address = 32'h4;  #1; check("preload_0x4", 32'h0000_1234);
    Address = 32'h20; #1; check("preload_0x20", 32'h0000_0001);
    Address = 32'h24; #1; check("preload_0x24", 32'h0);
`endif

    bus_op("wr_0x10", 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
    probe("rd_0x10", 32'h10, 1'b1);
    Address = 32'h13; #1; check("rd_0x13_unaligned", 32'hDEAD_BEEF);
    Address = 32'h14; #1; check("rd_0x14", model_read(32'h14, 1'b1));

    Address = 32'h10; MemRead = 1'b0; #1; check("rd_disabled", 32'h0);
    MemRead = 1'b1; #1; check("rd_enable_comb", 32'hDEAD_BEEF);

    bus_op("wr_0x20_old", 32'h20, 32'h11, 1'b0, 1'b1);
    @(negedge clk);
    Address = 32'h20; Write_data = 32'h22; MemRead = 1'b1; MemWrite = 1'b1;
    #1; check("rw_same_before", 32'h11);
    @(posedge clk); model[8] = 32'h22;
    #1; check("rw_same_after", 32'h22);
    MemWrite = 1'b0;

    bus_op("wr_0x0", 32'h0, 32'h5A5A_0001, 1'b0, 1'b1);
    bus_op("wr_oob_0x400", TOP_BYTE, 32'hFFFF_FFFF, 1'b1, 1'b1);
    probe("oob_rd_0x400", TOP_BYTE, 1'b1);
    Address = TOP_BYTE; #1; check("oob_rd_zero", 32'h0);
    Address = 32'h0; #1; check("word0_kept", 32'h5A5A_0001);
    bus_op("wr_last", TOP_BYTE - 4, 32'hCAFE_F00D, 1'b1, 1'b1);
    Address = TOP_BYTE - 4; #1; check("last_word", 32'hCAFE_F00D);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = TOP_BYTE + $urandom_range(0, 63);
        2:       a = {$urandom_range(0, 7), 2'b00};
        default: a = $urandom_range(0, TOP_BYTE - 1);
      endcase
      d = $urandom;
      bus_op("rand", a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    bus_op("pre_clr_w1", 32'h4, 32'h1111_1111, 1'b0, 1'b1);
    bus_op("pre_clr_w2", 32'h8, 32'h2222_2222, 1'b0, 1'b1);
    bus_op("pre_clr_w3", 32'hC, 32'h3333_3333, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    MemWrite = 1'b1; Write_data = 32'h7777_7777; Address = 32'h4;
    reset = 1'b0;
    model_reset();
    MemWrite = 1'b0;
    probe("async_clr_w1", 32'h4, 1'b1);
    probe("async_clr_w2", 32'h8, 1'b1);
    probe("async_clr_w3", 32'hC, 1'b1);
    @(negedge clk);
    Address = 32'h4; MemWrite = 1'b1; MemRead = 1'b1;
    @(posedge clk); #1;
    check("wr_blocked_in_reset", model_read(32'h4, 1'b1));
    @(negedge clk);
    MemWrite = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) probe("after_clr_sweep", i * 4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
